// File: rtl/rand_pkg.sv
// rand_pkg: shared types and constants for the random-request arbiter and its LFSR.
package rand_pkg;
    typedef enum logic [1:0] {IDLE, DRAW, RESP} rand_state_t;
    localparam int LFSR_W = 6;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 6'h3F;
    localparam int TAP_HI = 5;
    localparam int TAP_LO = 4;
endpackage

// File: rtl/rand_req_arbiter_lfsr6.sv
// lfsr6: free-running 6-bit Fibonacci LFSR (x^6+x^5+1) with seed load.
module lfsr6
    import rand_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);
    // A zero seed would lock the register, so it maps to the reset seed.
    always_ff @(posedge clk)
        if (rst) q <= LFSR_SEED;
        else if (load) q <= (seed == '0) ? LFSR_SEED : seed;
        else q <= {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
endmodule

// File: rtl/rand_req_arbiter.sv
// rand_req_arbiter: round-robin access to a shared LFSR with bounded rejection sampling.
module rand_req_arbiter
    import rand_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_TRIES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [6*N_REQ-1:0]   req_max,
    input  logic                 seed_valid,
    input  logic [LFSR_W-1:0]    seed,
    output logic [N_REQ-1:0]     ack,
    output logic [LFSR_W-1:0]    rsp_value,
    output logic                 rsp_fail,
    output logic                 busy,
    output logic [LFSR_W-1:0]    lfsr_q
);
    localparam int IW = $clog2(N_REQ);
    rand_state_t state;
    logic [IW-1:0] rr_ptr, winner, pick;
    logic [LFSR_W-1:0] max_q, pick_max;
    logic [3:0] tries;
    logic [N_REQ-1:0] win_hot;
    lfsr6 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (seed_valid && state == IDLE),
        .seed (seed),
        .q    (lfsr_q)
    );
    // Scan offsets from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        pick = rr_ptr;
        pick_max = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            for (int i = 0; i < N_REQ; i++)
                if (i == (int'(rr_ptr) + k) % N_REQ && req[i]) begin
                    pick = IW'(i);
                    pick_max = req_max[6*i +: 6];
                end
    end
    assign win_hot = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
    assign busy = state != IDLE;
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            winner <= '0;
            max_q <= '0;
            tries <= '0;
            ack <= '0;
            rsp_value <= '0;
            rsp_fail <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: if (|req) begin
                    winner <= pick;
                    max_q <= pick_max;
                    tries <= '0;
                    state <= DRAW;
                end
                DRAW: if (lfsr_q <= max_q) begin
                    rsp_value <= lfsr_q;
                    rsp_fail <= 1'b0;
                    ack <= win_hot;
                    state <= RESP;
                end else begin
                    tries <= tries + 4'd1;
                    if (tries + 4'd1 == 4'(MAX_TRIES)) begin
                        rsp_value <= '0;
                        rsp_fail <= 1'b1;
                        ack <= win_hot;
                        state <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_rand_req_arbiter.sv
// tb_rand_req_arbiter: scoreboard bench for rand_req_arbiter (MAX_TRIES 8 and 4 instances).
module tb_rand_req_arbiter;
    typedef struct {
        logic [3:0] ack;
        logic [5:0] value;
        logic       fail;
        int         cyc;
    } exp_t;
    logic clk = 0, rst = 1, seed_valid = 0;
    logic [3:0] req = 0, req4 = 0;
    logic [23:0] req_max = 0;
    logic [5:0] seed = 0;
    logic [3:0] ack, ack4;
    logic [5:0] rsp_value, rsp_value4, lfsr_q, lfsr_q4;
    logic rsp_fail, rsp_fail4, busy, busy4;
    int cyc = 0, checks = 0, errors = 0;
    exp_t q8[$], q4[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
    rand_req_arbiter #(.N_REQ(4), .MAX_TRIES(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_max(req_max), .seed_valid(seed_valid), .seed(seed),
        .ack(ack), .rsp_value(rsp_value), .rsp_fail(rsp_fail), .busy(busy), .lfsr_q(lfsr_q)
    );
    rand_req_arbiter #(.N_REQ(4), .MAX_TRIES(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .req_max(req_max), .seed_valid(seed_valid), .seed(seed),
        .ack(ack4), .rsp_value(rsp_value4), .rsp_fail(rsp_fail4), .busy(busy4), .lfsr_q(lfsr_q4)
    );
    // Reference sequence: n steps of x^6+x^5+1 from 3F.
    function automatic logic [5:0] lfsr_at(int n);
        logic [5:0] v = 6'h3F;
        for (int i = 0; i < n; i++) v = {v[4:0], v[5] ^ v[4]};
        return v;
    endfunction
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic push8(logic [3:0] a, logic [5:0] v, logic f, int c);
        exp_t e;
        e.ack = a; e.value = v; e.fail = f; e.cyc = c;
        q8.push_back(e);
    endtask
    task automatic do_reset();
        rst = 1; req = 0; req4 = 0; req_max = 0; seed_valid = 0; seed = 0;
        q8.delete(); q4.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask
    task automatic drain(int budget);
        int n = 0;
        exp_t e;
        while ((q8.size() != 0 || q4.size() != 0 || busy || busy4) && n < budget) begin
            @(negedge clk);
            n++;
            if (ack != 0) begin
                if (q8.size() == 0) chk("ack_unexpected", 32'(ack), 0);
                else begin
                    e = q8.pop_front();
                    chk("ack", 32'(ack), 32'(e.ack));
                    chk("value", 32'(rsp_value), 32'(e.value));
                    chk("fail", 32'(rsp_fail), 32'(e.fail));
                    chk("ack_cycle", cyc, e.cyc);
                end
                req = req & ~ack;
            end
            if (ack4 != 0) begin
                if (q4.size() == 0) chk("ack4_unexpected", 32'(ack4), 0);
                else begin
                    e = q4.pop_front();
                    chk("ack4", 32'(ack4), 32'(e.ack));
                    chk("value4", 32'(rsp_value4), 32'(e.value));
                    chk("fail4", 32'(rsp_fail4), 32'(e.fail));
                    chk("ack4_cycle", cyc, e.cyc);
                end
                req4 = req4 & ~ack4;
            end
        end
        chk("pending", q8.size() + q4.size(), 0);
    endtask
    task automatic rr_round();
        int t = cyc;
        req_max = {6'd0, 6'd63, 6'd0, 6'd63};
        req = 4'b0101;
        push8(4'b0001, lfsr_at(t + 1), 1'b0, t + 2);
        push8(4'b0100, lfsr_at(t + 4), 1'b0, t + 5);
        drain(40);
    endtask
    initial begin
        exp_t e;
        // Reset state, then a max-63 request accepts on the first draw.
        do_reset();
        @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_value", 32'(rsp_value), 0);
        chk("rst_fail", 32'(rsp_fail), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_lfsr", 32'(lfsr_q), 32'h3F);
        req = 4'b0001; req_max = {18'd0, 6'd63};
        push8(4'b0001, 6'h3E, 1'b0, 2);
        @(negedge clk);
        chk("busy_draw", 32'(busy), 1);
        drain(30);
        // Rejection sampling until 01 appears.
        do_reset();
        req = 4'b0010; req_max = {12'd0, 6'd5, 6'd0};
        push8(4'b0010, 6'h01, 1'b0, 7);
        drain(30);
        // Retry exhaustion on the MAX_TRIES=4 instance.
        do_reset();
        req4 = 4'b0001; req_max = {18'd0, 6'd5};
        e.ack = 4'b0001; e.value = 6'd0; e.fail = 1'b1; e.cyc = 5;
        q4.push_back(e);
        drain(30);
        // Round-robin fairness, including the wrap of rr_ptr back to 0.
        do_reset();
        rr_round();
        rr_round();
        // Zero seed in IDLE, then a seed attempt during DRAW must be ignored.
        do_reset();
        seed_valid = 1; seed = 6'd0;
        @(posedge clk); #1;
        seed_valid = 0;
        @(negedge clk);
        chk("seed_zero", 32'(lfsr_q), 32'h3F);
        req = 4'b0010; req_max = {12'd0, 6'd5, 6'd0};
        push8(4'b0010, 6'h01, 1'b0, 8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        seed_valid = 1; seed = 6'd15;
        @(posedge clk); #1;
        seed_valid = 0;
        @(negedge clk);
        chk("seed_ignored", 32'(lfsr_q), 32'h38);
        drain(30);
        // Reset in the second DRAW cycle aborts without an ack.
        do_reset();
        req = 4'b0001; req_max = {18'd0, 6'd5};
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; req = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_lfsr", 32'(lfsr_q), 32'h3F);
        for (int i = 0; i < 10; i++) begin
            chk("abort_no_ack", 32'(ack), 0);
            @(negedge clk);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rand_req_arbiter.md
# rand_req_arbiter

Shares one free-running 6-bit maximal-length LFSR among `N_REQ` game-logic requesters. Each requester asks for a random value bounded by its own inclusive maximum, for example a board cell or a piece index. The block arbitrates round-robin and draws by rejection sampling with a bounded retry count. It returns the value, or a failure flag, with a one-cycle acknowledge. It sits between the game FSMs and the random source, so no requester steps the LFSR directly.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `MAX_TRIES`, default 8: maximum draw cycles per request, 1..15.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: level request per requester; held until its `ack`.
- `req_max`  in  6*N_REQ: inclusive upper bound per requester, slice i = `[6i+5:6i]`; sampled on grant.
- `seed_valid`  in  1: load `seed` into the LFSR; honoured only in IDLE.
- `seed`  in  6: seed value; 0 is replaced by 6'h3F.
- `ack`  out  N_REQ: one-hot, one-cycle response strobe.
- `rsp_value`  out  6: drawn value, valid while `ack` is high.
- `rsp_fail`  out  1: retries exhausted, valid while `ack` is high.
- `busy`  out  1: high in any state other than IDLE.
- `lfsr_q`  out  6: current LFSR state, for debug and verification.

## Operation
- **LFSR:** Fibonacci, x^6+x^5+1, next = {lfsr[4:0], lfsr[5]^lfsr[4]}, period 63. It steps every cycle in every state, except in a cycle where a seed load is taken. State 0 is unreachable.
- **FSM states:** IDLE, DRAW, RESP.
- **IDLE:**
  - If any `req` bit is high, pick the winner round-robin starting at `rr_ptr`.
  - Latch the winner id and its `req_max`, clear `tries`, and go to DRAW.
  - If `seed_valid` is high in the same cycle, the seed load also happens. The first DRAW then samples the loaded seed.
- **DRAW:** each cycle, compare `lfsr_q` with the latched max.
  - `lfsr_q <= max`: latch `rsp_value = lfsr_q`, `rsp_fail = 0`, go to RESP.
  - Otherwise, increment `tries`. If `tries` reaches `MAX_TRIES`, latch `rsp_value = 0`, `rsp_fail = 1`, go to RESP.
- **RESP:**
  - Assert `ack[winner]` for exactly one cycle.
  - Set `rr_ptr = (winner+1) mod N_REQ` and return to IDLE.
- **Requester rule:** drop `req` in the cycle after `ack`. A `req` still high in IDLE is treated as a new request.
- **Requester input changes:** `req` bits and `req_max` changing during DRAW/RESP do not affect the transaction in flight.
- **Ignored seed loads:** `seed_valid` outside IDLE is ignored and not queued.
- **Max of 63:** a `req_max` of 63 always accepts on the first draw.

## Timing
- **Reset values:** state IDLE, `lfsr_q` = 6'h3F, `rr_ptr` = 0, `tries` = 0, `ack` = 0, `rsp_value` = 0, `rsp_fail` = 0, `busy` = 0.
- **Cycle numbering:** the first cycle after `rst` deasserts is cycle 0, with `lfsr_q` = 3F.
- **Latency:** `req` seen in IDLE at cycle t → DRAW from t+1.
  - First-draw accept gives `ack` at t+2.
  - Worst case gives `ack` at t+1+`MAX_TRIES`.
  - Back-to-back transactions are spaced 1 IDLE cycle apart.
- **Seed load:** `lfsr_q` equals the loaded seed in the cycle after the load.
- **Reset mid-transaction:** `rst` in DRAW or RESP aborts with no `ack`. All registers take their reset values next cycle.
- **Reference LFSR sequence from 3F:** 3E, 3C, 38, 30, 20, 01, 02, 04, 08, 10, 21.

## Structure
- **Package `rand_pkg`:**
  - state enum `rand_state_t` (IDLE, DRAW, RESP);
  - `LFSR_SEED` = 6'h3F;
  - `LFSR_W` = 6;
  - tap positions.
- **Sub-module `lfsr6`:** ports `clk`, `rst`, `load`, `seed`, `q`. It steps every cycle unless `load` is high and applies the zero-seed substitution.
- **Top level:** arbiter, FSM, retry counter and response registers.

## Test plan
- Reset, then `req[0]` with max 63 at cycle 0 → `ack` = 4'b0001 at cycle 2, `rsp_value` = 3E, `rsp_fail` = 0.
- Reset, then `req[1]` with max 5 at cycle 0 (`MAX_TRIES` = 8) → draws 3E, 3C, 38, 30, 20, 01; `ack[1]` at cycle 7, `rsp_value` = 01.
- `MAX_TRIES` = 4, reset, then `req[0]` with max 5 → `ack[0]` at cycle 5, `rsp_fail` = 1, `rsp_value` = 0.
- Reset, then `req[0]` and `req[2]` held together, each dropped after its own `ack` → `ack[0]` first, then `ack[2]`. Re-raise both → `rr_ptr` = 3 wraps to grant 0 first again; no requester is starved.
- `seed_valid` with seed 0 in IDLE → `lfsr_q` = 3F next cycle. `seed_valid` with 15 during DRAW → ignored, LFSR sequence unchanged.
- `rst` pulsed in the second DRAW cycle → no `ack` is ever produced, `busy` = 0, and `lfsr_q` = 3F in the cycle after reset.
